// File: rtl/pipe_stage_reg_if.sv
// Handshake bundle carried between two pipeline stages: valid/ready plus
// payload, control vector and instruction word.
interface pipe_stage_reg_if #(
    parameter int unsigned DW = 64,
    parameter int unsigned CW = 24
);
    logic          valid;
    logic          ready;
    logic [DW-1:0] data;
    logic [CW-1:0] ctrl;
    logic [15:0]   instr;

    modport master (output valid, data, ctrl, instr, input ready);
    modport slave  (input valid, data, ctrl, instr, output ready);
endinterface

// File: rtl/pipe_stage_reg.sv
// Parametrised valid/ready pipeline-stage register with flush, bubble masking
// and a saturating stall counter. Define PIPE_STAGE_SKID_EN for a 2-entry skid stage.
module pipe_stage_reg #(
    parameter int unsigned   DW        = 64,
    parameter int unsigned   CW        = 24,
    parameter logic [CW-1:0] KILL_MASK = {CW{1'b1}},
    parameter logic [15:0]   NOP_INSTR = 16'h0800,
    parameter int unsigned   SCW       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             stat_clr,
    output logic [SCW-1:0]   stall_cnt,
    pipe_stage_reg_if.slave  up,
    pipe_stage_reg_if.master dn
);

    typedef struct packed {
        logic [DW-1:0] data;
        logic [CW-1:0] ctrl;
        logic [15:0]   instr;
    } entry_t;

    localparam entry_t RST_ENTRY = '{data: {DW{1'b0}}, ctrl: {CW{1'b0}}, instr: NOP_INSTR};

    entry_t         r_main;
    logic           r_valid;
    logic [SCW-1:0] r_stall_cnt;
    entry_t         w_in_entry;
    logic           w_in_ready;
    logic           w_in_fire;
    logic           w_out_fire;

    // Handshake decode shared by both build variants.
    always_comb begin
        w_in_entry = '{data: up.data, ctrl: up.ctrl, instr: up.instr};
        w_in_fire  = up.valid & w_in_ready;
        w_out_fire = r_valid & dn.ready;
    end

`ifdef PIPE_STAGE_SKID_EN
    entry_t r_skid;
    logic   r_skid_valid;

    // in_ready comes straight from a flop, breaking the ready path to upstream.
    always_comb begin
        w_in_ready = ~r_skid_valid;
    end

    // Main + skid storage: the skid slot always holds the younger entry.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid      <= 1'b0;
            r_main       <= RST_ENTRY;
            r_skid_valid <= 1'b0;
            r_skid       <= RST_ENTRY;
        end else if (flush) begin
            r_valid      <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (w_out_fire) begin
            if (r_skid_valid) begin
                r_main       <= r_skid;
                r_skid_valid <= w_in_fire;
                if (w_in_fire) begin
                    r_skid <= w_in_entry;
                end
            end else if (w_in_fire) begin
                r_main <= w_in_entry;
            end else begin
                r_valid <= 1'b0;
            end
        end else if (w_in_fire) begin
            if (r_valid) begin
                r_skid       <= w_in_entry;
                r_skid_valid <= 1'b1;
            end else begin
                r_main  <= w_in_entry;
                r_valid <= 1'b1;
            end
        end
    end
`else
    // Upstream may load whenever the slot is empty or being drained this cycle.
    always_comb begin
        w_in_ready = ~r_valid | dn.ready;
    end

    // Single-slot storage: flush beats load, load beats drain.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid <= 1'b0;
            r_main  <= RST_ENTRY;
        end else if (flush) begin
            r_valid <= 1'b0;
        end else if (w_in_fire) begin
            r_main  <= w_in_entry;
            r_valid <= 1'b1;
        end else if (w_out_fire) begin
            r_valid <= 1'b0;
        end
    end
`endif

    // Stall counter: clear wins over increment, sticks at all-ones, survives flush.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stall_cnt <= {SCW{1'b0}};
        end else if (stat_clr) begin
            r_stall_cnt <= {SCW{1'b0}};
        end else if (r_valid && !dn.ready && !(&r_stall_cnt)) begin
            r_stall_cnt <= r_stall_cnt + {{(SCW-1){1'b0}}, 1'b1};
        end
    end

    // Bubbles present killed control bits and a NOP; payload is left as held.
    always_comb begin
        up.ready  = w_in_ready;
        dn.valid  = r_valid;
        dn.data   = r_main.data;
        stall_cnt = r_stall_cnt;
        if (r_valid) begin
            dn.ctrl  = r_main.ctrl;
            dn.instr = r_main.instr;
        end else begin
            dn.ctrl  = r_main.ctrl & ~KILL_MASK;
            dn.instr = NOP_INSTR;
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Randomised + directed bench for pipe_stage_reg: two instances (default and
// SCW=4 with a partial kill mask) checked against a queue-based model.
module tb_pipe_stage_reg;

    localparam logic [23:0] MASK_A = 24'hFFFFFF;
    localparam logic [23:0] MASK_B = 24'h00FF0F;

    typedef struct packed {
        logic [63:0] d;
        logic [23:0] c;
        logic [15:0] i;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        t_flush, t_stat_clr, t_in_valid, t_out_ready;
    logic [63:0] t_data;
    logic [23:0] t_ctrl;
    logic [15:0] t_instr;
    logic [15:0] cnt_a_o;
    logic [3:0]  cnt_b_o;

    int   n_checks = 0;
    int   n_pass   = 0;
    ent_t q[$];
    ent_t last;
    int   cnt_a, cnt_b;

    always #5 clk = ~clk;

    pipe_stage_reg_if #(.DW(64), .CW(24)) ua ();
    pipe_stage_reg_if #(.DW(64), .CW(24)) da ();
    pipe_stage_reg_if #(.DW(64), .CW(24)) ub ();
    pipe_stage_reg_if #(.DW(64), .CW(24)) db ();

    assign ua.valid = t_in_valid;
    assign ua.data  = t_data;
    assign ua.ctrl  = t_ctrl;
    assign ua.instr = t_instr;
    assign ub.valid = t_in_valid;
    assign ub.data  = t_data;
    assign ub.ctrl  = t_ctrl;
    assign ub.instr = t_instr;
    assign da.ready = t_out_ready;
    assign db.ready = t_out_ready;

    pipe_stage_reg dut_a (
        .clk(clk), .rst(rst), .flush(t_flush), .stat_clr(t_stat_clr),
        .stall_cnt(cnt_a_o), .up(ua), .dn(da)
    );

    pipe_stage_reg #(.DW(64), .CW(24), .KILL_MASK(MASK_B), .NOP_INSTR(16'h0800), .SCW(4)) dut_b (
        .clk(clk), .rst(rst), .flush(t_flush), .stat_clr(t_stat_clr),
        .stall_cnt(cnt_b_o), .up(ub), .dn(db)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    function automatic logic exp_in_ready();
`ifdef PIPE_STAGE_SKID_EN
        return q.size() < 2;
`else
        return (q.size() == 0) || t_out_ready;
`endif
    endfunction

    task automatic model_reset();
        q.delete();
        last  = '{d: 64'd0, c: 24'd0, i: 16'h0800};
        cnt_a = 0;
        cnt_b = 0;
    endtask

    task automatic check_all();
        logic rdy;
        rdy = exp_in_ready();
        chk("a_in_ready", {63'd0, ua.ready}, {63'd0, rdy});
        chk("b_in_ready", {63'd0, ub.ready}, {63'd0, rdy});
        chk("a_out_valid", {63'd0, da.valid}, {63'd0, q.size() > 0});
        chk("b_out_valid", {63'd0, db.valid}, {63'd0, q.size() > 0});
        if (q.size() > 0) begin
            chk("a_out_data", da.data, q[0].d);
            chk("a_out_ctrl", {40'd0, da.ctrl}, {40'd0, q[0].c});
            chk("a_out_instr", {48'd0, da.instr}, {48'd0, q[0].i});
            chk("b_out_data", db.data, q[0].d);
            chk("b_out_ctrl", {40'd0, db.ctrl}, {40'd0, q[0].c});
        end else begin
            chk("a_bubble_ctrl", {40'd0, da.ctrl}, {40'd0, last.c & ~MASK_A});
            chk("b_bubble_ctrl", {40'd0, db.ctrl}, {40'd0, last.c & ~MASK_B});
            chk("a_bubble_instr", {48'd0, da.instr}, 64'h0800);
            chk("b_bubble_instr", {48'd0, db.instr}, 64'h0800);
        end
        chk("a_stall_cnt", {48'd0, cnt_a_o}, 64'(cnt_a));
        chk("b_stall_cnt", {60'd0, cnt_b_o}, 64'(cnt_b));
    endtask

    // Advance the model by one clock edge using the inputs currently applied.
    task automatic model_step();
        logic in_fire, out_fire, stall;
        in_fire  = t_in_valid && exp_in_ready();
        out_fire = (q.size() > 0) && t_out_ready;
        stall    = (q.size() > 0) && !t_out_ready;
        if (t_stat_clr) begin
            cnt_a = 0;
            cnt_b = 0;
        end else if (stall) begin
            if (cnt_a < 65535) cnt_a++;
            if (cnt_b < 15) cnt_b++;
        end
        if (t_flush) begin
            q.delete();
        end else begin
            if (out_fire) void'(q.pop_front());
            if (in_fire) q.push_back('{d: t_data, c: t_ctrl, i: t_instr});
        end
        if (q.size() > 0) last = q[0];
    endtask

    task automatic sample();
        @(negedge clk);
        check_all();
    endtask

    task automatic advance();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic cycle();
        sample();
        advance();
    endtask

    task automatic drive(input logic iv, input logic ordy, input logic [63:0] d,
                         input logic [23:0] c, input logic [15:0] ins,
                         input logic fl, input logic sc);
        t_in_valid  = iv;
        t_out_ready = ordy;
        t_data      = d;
        t_ctrl      = c;
        t_instr     = ins;
        t_flush     = fl;
        t_stat_clr  = sc;
    endtask

    initial begin
        rst = 1'b0;
        drive(1'b0, 1'b0, 64'd0, 24'd0, 16'd0, 1'b0, 1'b0);
        model_reset();
        #2;
        check_all();
        chk("reset_out_instr", {48'd0, da.instr}, 64'h0800);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Streaming at one entry per cycle.
        drive(1'b0, 1'b1, 64'd0, 24'd0, 16'd0, 1'b1, 1'b1);
        cycle();
        for (int i = 0; i < 9; i++) begin
            drive(i < 8, 1'b1, 64'(i), 24'(i * 3), 16'(16'h1000 + i), 1'b0, 1'b0);
            sample();
            if (i > 0) begin
                chk("stream_data", da.data, 64'(i - 1));
                chk("stream_in_ready", {63'd0, ua.ready}, 64'd1);
                chk("stream_stall", {48'd0, cnt_a_o}, 64'd0);
            end
            advance();
        end

        // Back-pressure: A held for five stall cycles while B waits.
        drive(1'b1, 1'b1, 64'hAAAA, 24'h000A, 16'h0A0A, 1'b0, 1'b1);
        cycle();
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, 1'b0, 64'hBBBB, 24'h000B, 16'h0B0B, 1'b0, 1'b0);
            sample();
            chk("bp_hold_A", da.data, 64'hAAAA);
`ifdef PIPE_STAGE_SKID_EN
            chk("bp_in_ready", {63'd0, ua.ready}, {63'd0, k == 0});
`else
            chk("bp_in_ready", {63'd0, ua.ready}, 64'd0);
`endif
            advance();
        end
        drive(1'b1, 1'b1, 64'hBBBB, 24'h000B, 16'h0B0B, 1'b0, 1'b0);
        sample();
        chk("bp_stall_cnt", {48'd0, cnt_a_o}, 64'd5);
        chk("bp_release_A", da.data, 64'hAAAA);
        advance();
        drive(1'b0, 1'b1, 64'd0, 24'd0, 16'd0, 1'b0, 1'b0);
        sample();
        chk("bp_then_B", da.data, 64'hBBBB);
        advance();
        cycle();

        // Flush while stalled with all control bits set; incoming D is dropped.
        drive(1'b1, 1'b1, 64'hCCCC, 24'hFFFFFF, 16'h0C0C, 1'b0, 1'b0);
        cycle();
        drive(1'b0, 1'b0, 64'd0, 24'd0, 16'd0, 1'b0, 1'b0);
        cycle();
        drive(1'b1, 1'b0, 64'hDDDD, 24'h00000D, 16'h0D0D, 1'b1, 1'b0);
        cycle();
        drive(1'b0, 1'b1, 64'd0, 24'd0, 16'd0, 1'b0, 1'b0);
        sample();
        chk("flush_valid", {63'd0, da.valid}, 64'd0);
        chk("flush_ctrl_a", {40'd0, da.ctrl}, 64'd0);
        chk("flush_ctrl_b", {40'd0, db.ctrl}, 64'hFF00F0);
        chk("flush_instr", {48'd0, da.instr}, 64'h0800);
        advance();
        cycle();

        // Saturation of the 4-bit counter, then clear during a stall.
        drive(1'b0, 1'b0, 64'd0, 24'd0, 16'd0, 1'b1, 1'b1);
        cycle();
        drive(1'b1, 1'b1, 64'hEEEE, 24'h00000E, 16'h0E0E, 1'b0, 1'b0);
        cycle();
        drive(1'b0, 1'b0, 64'd0, 24'd0, 16'd0, 1'b0, 1'b0);
        for (int k = 0; k < 20; k++) cycle();
        sample();
        chk("sat_cnt_b", {60'd0, cnt_b_o}, 64'd15);
        chk("sat_cnt_a", {48'd0, cnt_a_o}, 64'd20);
        t_stat_clr = 1'b1;
        advance();
        t_stat_clr = 1'b0;
        sample();
        chk("clr_cnt_b", {60'd0, cnt_b_o}, 64'd0);
        chk("clr_cnt_a", {48'd0, cnt_a_o}, 64'd0);
        advance();

        // Random traffic against the model.
        for (int n = 0; n < 600; n++) begin
            drive($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 6,
                  {$urandom(), $urandom()}, 24'($urandom()), 16'($urandom()),
                  $urandom_range(0, 99) < 5, $urandom_range(0, 99) < 3);
            cycle();
        end

        // Asynchronous reset while holding a stalled entry.
        drive(1'b1, 1'b0, 64'h1234, 24'h000123, 16'h1234, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) cycle();
        drive(1'b0, 1'b0, 64'd0, 24'd0, 16'd0, 1'b0, 1'b0);
        rst = 1'b0;
        #2;
        chk("arst_valid", {63'd0, da.valid}, 64'd0);
        chk("arst_instr", {48'd0, da.instr}, 64'h0800);
        chk("arst_cnt", {48'd0, cnt_a_o}, 64'd0);
        model_reset();
        check_all();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        drive(1'b0, 1'b1, 64'd0, 24'd0, 16'd0, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) cycle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
Parametrised pipeline-stage register, successor to the fixed-field inter-stage latches.
- Carries a generic data payload, a control-bit vector and the instruction word between any two pipeline stages.
- Uses a valid/ready handshake in place of a bare enable.
- Supports synchronous flush: inserts a bubble, drops masked control bits (write enables, memory enables) and presents a NOP instruction.
- Keeps a saturating back-pressure counter for performance debug.

Parameters:
DW, 64, payload width in bits (operands, immediate, PC+2 concatenated by the instantiating stage)
CW, 24, control vector width
KILL_MASK, {CW{1'b1}}, control bits forced to 0 whenever the stage holds a bubble
NOP_INSTR, 16'h0800, instruction word presented when the stage holds a bubble
SCW, 16, stall counter width

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-low
flush  input  1  synchronous kill of all held and incoming entries
in_valid  input  1  upstream entry valid
in_ready  output  1  stage can accept an entry this cycle
in_data  input  DW  payload
in_ctrl  input  CW  control bits
in_instr  input  16  instruction word
out_valid  output  1  stage holds a valid entry
out_ready  input  1  downstream accepts the entry this cycle
out_data  output  DW  held payload
out_ctrl  output  CW  held control bits, masked by KILL_MASK when not valid
out_instr  output  16  held instruction, or NOP_INSTR when not valid
stat_clr  input  1  synchronous clear of stall_cnt
stall_cnt  output  SCW  cycles with out_valid=1 and out_ready=0, saturating

Behaviour:
- Reset, rst=0, asynchronous, all state:
  - valid_q=0, data_q=0, ctrl_q=0, instr_q=NOP_INSTR, stall_cnt=0, skid state cleared.
  - Outputs follow immediately: out_valid=0, out_ctrl=0, out_instr=NOP_INSTR.
- Handshakes:
  - in_fire = in_valid & in_ready.
  - out_fire = out_valid & out_ready.
  - Latency is 1 cycle: an entry accepted at edge N is visible on out_* after edge N.
- Base mode (no skid):
  - in_ready = ~valid_q | out_ready (combinational from out_ready).
  - Edge actions, in priority order:
    1. flush: valid_q<=0.
    2. in_fire: load all fields and set valid_q<=1.
    3. out_fire without in_fire: valid_q<=0.
    4. Otherwise: hold.
  - Back-to-back transfers sustain 1 entry/cycle.
- Output masking:
  - out_ctrl = valid_q ? ctrl_q : ctrl_q & ~KILL_MASK.
  - out_instr = valid_q ? instr_q : NOP_INSTR.
  - out_data is unmasked; its value is don't-care while invalid, but it is held (not cleared).
- Flush:
  - Highest priority; overrides in_fire and out_fire in the same cycle.
  - The incoming entry is discarded.
  - in_ready is still driven per its formula during flush, so upstream sees its entry consumed.
- Stall counter:
  - Increments on each edge with out_valid & ~out_ready.
  - Saturates at all-ones, no wrap.
  - stat_clr has priority over increment.
  - flush does not clear the counter.
- Reset mid-transfer: any in-flight entry is lost; nothing is forwarded after reset deasserts until a new in_fire.

Optional Feature:
PIPE_STAGE_SKID_EN.
- Defined:
  - Adds a one-entry skid register (skid_valid plus copies of all fields).
  - in_ready = ~skid_valid, a pure flop output with no combinational path from out_ready.
  - An in_fire while valid_q=1 and out_ready=0 captures into skid.
  - On out_fire with skid_valid=1, skid moves to main and skid_valid<=0; an in_fire in that same cycle lands in skid.
  - flush clears both valid_q and skid_valid.
  - Capacity is 2 entries; order is strictly FIFO.
- Undefined: base mode only; skid logic absent.

Test Plan:
1. Streaming: in_valid=1, out_ready=1 for 8 cycles, in_data=0..7 -> out_data=0..7 one cycle later, in_ready stays 1, stall_cnt=0.
2. Back-pressure: load entry A; hold out_ready=0 for 5 cycles with in_valid=1 and data B -> out_data=A throughout.
   - Base mode: in_ready=0.
   - Skid mode: B accepted once, then in_ready=0.
   - stall_cnt=5. Release out_ready -> A then B delivered in order.
3. Flush with stall: hold valid entry (ctrl=all ones) with out_ready=0, assert flush together with in_valid=1 -> next cycle out_valid=0, out_ctrl=ctrl_q&~KILL_MASK (=0 with default mask), out_instr=16'h0800, incoming entry never appears.
4. Reset mid-operation: rst low asynchronously while out_valid=1 -> out_valid=0, out_instr=16'h0800, stall_cnt=0 before the next clock edge.
5. Counter saturation: with SCW=4, stall 20 cycles -> stall_cnt=15; then stat_clr=1 together with a stall cycle -> stall_cnt=0.
